// File: rtl/bp_pkg.sv
// +---------------------------------------------------------------------------+
// | bp_pkg - shared constants, FSM state type and counter helper for the BHT   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

  localparam int CNT_W_MAX = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Counter is carried at the widest legal width; callers truncate to cnt_w.
  function automatic logic [CNT_W_MAX-1:0] sat_update(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic                 taken,
    input int                   cnt_w
  );
    logic [CNT_W_MAX-1:0] max_v;
    max_v = CNT_W_MAX'((1 << cnt_w) - 1);
    if (taken) begin
      sat_update = (cnt >= max_v) ? max_v : cnt + CNT_W_MAX'(1);
    end else begin
      sat_update = (cnt == '0) ? '0 : cnt - CNT_W_MAX'(1);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// +---------------------------------------------------------------------------+
// | bp_sat_counter - combinational saturating up/down next-value logic        |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W_MAX-1:0] w_next_wide;

  assign w_next_wide = sat_update(CNT_W_MAX'(cnt_i), taken_i, CNT_W);
  assign cnt_o       = w_next_wide[CNT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/branch_predict_bht.sv
// +---------------------------------------------------------------------------+
// | branch_predict_bht - bimodal/gshare branch history table with statistics  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module branch_predict_bht
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic             ready,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [31:0]      br_cnt,
  output logic [31:0]      miss_cnt
);

  localparam int             DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'((1 << (CNT_W - 1)) - 1);

  bp_state_e        state_q;
  logic             ready_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ghr_q,      ghr_d;
  logic [31:0]      br_cnt_q,   br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] table_q [DEPTH];

  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ghr_shift;
  logic             w_upd_fire;
  logic [CNT_W-1:0] w_sat_next;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [CNT_W-1:0] w_wdata;
  logic             w_unused;

  assign w_pc_idx = if_pc[IDX_W+1:2];
  assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], ghr_q};

  generate
    if (MODE == BP_GSHARE) begin : g_gshare
      assign w_idx = w_pc_idx ^ ghr_q;
    end else begin : g_bimodal
      assign w_idx = w_pc_idx;
    end
  endgenerate

  generate
    if (IDX_W == 1) begin : g_ghr_w1
      assign w_ghr_shift = upd_taken;
    end else begin : g_ghr_wn
      assign w_ghr_shift = {ghr_q[IDX_W-2:0], upd_taken};
    end
  endgenerate

  // Read is straight from the flops: an update this cycle shows up next cycle.
  assign pred_idx   = w_idx;
  assign pred_taken = ready_q & table_q[w_idx][CNT_W-1];
  assign ready      = ready_q;
  assign br_cnt     = br_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  assign w_upd_fire = (state_q == ST_RUN) && upd_valid && !stall;

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat (
    .cnt_i   (table_q[upd_idx]),
    .taken_i (upd_taken),
    .cnt_o   (w_sat_next)
  );

  // Single write port shared by the init sweep and the update path.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = ptr_q;
    w_wdata = INIT_VAL;
    if (state_q == ST_INIT) begin
      w_we = 1'b1;
    end else if (w_upd_fire) begin
      w_we    = 1'b1;
      w_waddr = upd_idx;
      w_wdata = w_sat_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      table_q[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ghr_d      = ghr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (w_upd_fire) begin
      ghr_d = w_ghr_shift;
      if (br_cnt_q != 32'hFFFF_FFFF) begin
        br_cnt_d = br_cnt_q + 32'd1;
      end
      if ((upd_taken != upd_pred) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q      <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      ghr_q      <= ghr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_bht.sv
// +---------------------------------------------------------------------------+
// | tb_branch_predict_bht - bimodal, gshare and 1-bit BHT against a table model|
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_branch_predict_bht;

  localparam int N     = 3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n, stall, upd_valid, upd_taken, upd_pred;
  logic [31:0] if_pc;
  logic [3:0]  upd_idx;

  logic        d_pred  [N];
  logic [3:0]  d_idx   [N];
  logic        d_ready [N];
  logic [31:0] d_br    [N];
  logic [31:0] d_miss  [N];

  always #5 clk = ~clk;

  branch_predict_bht #(.IDX_W(4), .CNT_W(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
    .pred_taken(d_pred[0]), .pred_idx(d_idx[0]), .ready(d_ready[0]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .br_cnt(d_br[0]), .miss_cnt(d_miss[0]));

  branch_predict_bht #(.IDX_W(4), .CNT_W(2), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
    .pred_taken(d_pred[1]), .pred_idx(d_idx[1]), .ready(d_ready[1]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .br_cnt(d_br[1]), .miss_cnt(d_miss[1]));

  branch_predict_bht #(.IDX_W(4), .CNT_W(1), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
    .pred_taken(d_pred[2]), .pred_idx(d_idx[2]), .ready(d_ready[2]),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .br_cnt(d_br[2]), .miss_cnt(d_miss[2]));

  // Reference model: counter values as plain integers, init as a cycle count.
  int     cw [N] = '{2, 2, 1};
  int     md [N] = '{0, 1, 0};
  int     m_tab  [N][DEPTH];
  int     m_init [N];
  int     m_ghr  [N];
  longint m_br   [N];
  longint m_miss [N];
  int     mx;
  bit     chk_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_index(input int k);
    return ((if_pc >> 2) & 15) ^ (md[k] == 1 ? m_ghr[k] : 0);
  endfunction

  function automatic int m_predict(input int k);
    if (m_init[k] != DEPTH) return 0;
    return (m_tab[k][m_index(k)] >= (1 << (cw[k] - 1))) ? 1 : 0;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      m_init[k] = 0; m_ghr[k] = 0; m_br[k] = 0; m_miss[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        m_init[k] = 0; m_ghr[k] = 0; m_br[k] = 0; m_miss[k] = 0;
      end else if (m_init[k] < DEPTH) begin
        m_init[k]++;
        if (m_init[k] == DEPTH)
          for (int j = 0; j < DEPTH; j++) m_tab[k][j] = (1 << (cw[k] - 1)) - 1;
      end else if (upd_valid && !stall) begin
        mx = (1 << cw[k]) - 1;
        if (upd_taken) m_tab[k][upd_idx] = (m_tab[k][upd_idx] < mx) ? m_tab[k][upd_idx] + 1 : mx;
        else           m_tab[k][upd_idx] = (m_tab[k][upd_idx] > 0) ? m_tab[k][upd_idx] - 1 : 0;
        m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) & 15;
        if (m_br[k] < 64'hFFFF_FFFF) m_br[k]++;
        if (upd_taken != upd_pred && m_miss[k] < 64'hFFFF_FFFF) m_miss[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("u%0d.ready", k), 32'(d_ready[k]), 32'(m_init[k] == DEPTH));
        check($sformatf("u%0d.pred_taken", k), 32'(d_pred[k]), 32'(m_predict(k)));
        check($sformatf("u%0d.pred_idx", k), 32'(d_idx[k]), 32'(m_index(k)));
        check($sformatf("u%0d.br_cnt", k), d_br[k], m_br[k][31:0]);
        check($sformatf("u%0d.miss_cnt", k), d_miss[k], m_miss[k][31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(input int idx, input bit t, input bit p);
    upd_valid = 1'b1;
    upd_idx   = 4'(idx);
    upd_taken = t;
    upd_pred  = p;
    tick();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic init_window();
    for (int i = 0; i < DEPTH; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check("init.ready_low", 32'(d_ready[0]), 32'd0);
      check("init.pred_low", 32'(d_pred[0]), 32'd0);
      tick();
    end
    #1;
    check("init.ready_high", 32'(d_ready[0]), 32'd1);
  endtask

  typedef struct { logic [31:0] pc; int idx; bit t; bit p; } vec_t;
  vec_t vecs [8];

  initial begin
    rst_n = 1'b0; stall = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_pred = 1'b0; upd_idx = '0; if_pc = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Updates offered during the sweep must be dropped.
    upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; upd_pred = 1'b0;
    init_window();
    upd_valid = 1'b0;
    check("init.br_cnt", d_br[0], 32'd0);

    if_pc = 32'h14;
    upd(5, 1'b1, 1'b0);
    check("sat.pred_after_t1", 32'(d_pred[0]), 32'd1);
    check("w1.pred_after_t", 32'(d_pred[2]), 32'd1);
    upd(5, 1'b1, 1'b1);
    upd(5, 1'b1, 1'b1);
    check("sat.pred_after_t3", 32'(d_pred[0]), 32'd1);

    stall = 1'b1; upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b0; upd_pred = 1'b1;
    tick(); tick();
    stall = 1'b0; upd_valid = 1'b0;
    #1;
    check("stall.br_cnt", d_br[0], 32'd3);
    check("stall.miss_cnt", d_miss[0], 32'd1);
    check("stall.pred", 32'(d_pred[0]), 32'd1);

    upd(5, 1'b0, 1'b1);
    check("w1.pred_after_nt", 32'(d_pred[2]), 32'd0);
    upd(5, 1'b0, 1'b1);
    check("sat.pred_after_nt2", 32'(d_pred[0]), 32'd0);
    upd(5, 1'b0, 1'b0);
    upd(5, 1'b0, 1'b0);

    // Mid-RUN reset, then statistics and gshare history.
    rst_n = 1'b0;
    upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; upd_pred = 1'b0;
    tick();
    upd_valid = 1'b0;
    rst_n = 1'b1;
    init_window();
    for (int i = 0; i < DEPTH; i++) begin
      if_pc = 32'(i * 4);
      tick();
    end
    upd(2, 1'b1, 1'b1);
    upd(9, 1'b1, 1'b0);
    if_pc = 32'h40;
    #1;
    check("gshare.pred_idx", 32'(d_idx[1]), 32'd3);
    upd(3, 1'b0, 1'b1);
    upd(4, 1'b0, 1'b0);
    check("stats.br_cnt", d_br[0], 32'd4);
    check("stats.miss_cnt", d_miss[0], 32'd2);

    // Reset in the middle of the sweep, with pointer at 7.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    init_window();
    check("midinit.br_cnt", d_br[0], 32'd0);

    // Counter saturation from a preloaded near-max value.
    force u0.br_cnt_q   = 32'hFFFF_FFFE;
    force u0.miss_cnt_q = 32'hFFFF_FFFE;
    m_br[0]   = 64'hFFFF_FFFE;
    m_miss[0] = 64'hFFFF_FFFE;
    #1;
    release u0.br_cnt_q;
    release u0.miss_cnt_q;
    upd(1, 1'b1, 1'b0);
    upd(1, 1'b0, 1'b1);
    check("satcnt.br_cnt", d_br[0], 32'hFFFF_FFFF);
    check("satcnt.miss_cnt", d_miss[0], 32'hFFFF_FFFF);

    vecs = '{'{32'h0000_0004, 1, 1'b1, 1'b0}, '{32'h0000_0004, 1, 1'b1, 1'b1},
             '{32'h0000_003C, 15, 1'b1, 1'b0}, '{32'h0000_1020, 8, 1'b0, 1'b0},
             '{32'h0000_0004, 1, 1'b0, 1'b1}, '{32'hFFFF_FFFC, 15, 1'b1, 1'b1},
             '{32'h0000_0020, 8, 1'b1, 1'b0}, '{32'h0000_0024, 9, 1'b0, 1'b1}};
    foreach (vecs[i]) begin
      if_pc = vecs[i].pc;
      upd(vecs[i].idx, vecs[i].t, vecs[i].p);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predict_bht.md
BRANCH_PREDICT_BHT -- requirements
Module: branch_predict_bht

Interface
REQ-001 SHALL have parameter IDX_W, default 6: table holds 2^IDX_W counters.
REQ-002 SHALL have parameter CNT_W, default 2: saturating counter width, legal range 1..4.
REQ-003 SHALL have parameter MODE, default 0: 0 = bimodal (PC-indexed), 1 = gshare (PC XOR global history).
REQ-004 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  pipeline stall; gates updates and statistics.
- if_pc  in  32  PC of the instruction in IF.
- pred_taken  out  1  prediction for if_pc.
- pred_idx  out  IDX_W  table index used for if_pc; the pipeline carries it to ID.
- ready  out  1  table initialised; predictions are valid.
- upd_valid  in  1  a resolved BEQ/BNE is in ID.
- upd_idx  in  IDX_W  pred_idx captured for that branch.
- upd_taken  in  1  actual branch outcome.
- upd_pred  in  1  prediction originally issued for that branch.
- br_cnt  out  32  resolved-branch count.
- miss_cnt  out  32  mispredict count.

Function
REQ-005 Index SHALL be if_pc[IDX_W+1:2] when MODE=0, and if_pc[IDX_W+1:2] XOR ghr when MODE=1.
REQ-006 pred_idx SHALL be that index.
REQ-007 pred_taken SHALL be combinational: MSB of table[pred_idx] when ready=1, else 0.
REQ-008 Read SHALL return the registered table contents. No same-cycle bypass: a simultaneous update to the same index is visible from the next cycle.
REQ-009 FSM SHALL have exactly two states, INIT and RUN. Reset enters INIT with sweep pointer 0.
REQ-010 INIT SHALL write INIT_VAL = 2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1) to one entry per cycle, pointer ascending. After writing entry 2^IDX_W-1 it moves to RUN.
REQ-011 ready SHALL be 0 in INIT and 1 in RUN. INIT therefore lasts exactly 2^IDX_W cycles.
REQ-012 In INIT, upd_valid SHALL be ignored: no table, ghr or statistic change.
REQ-013 In RUN, an update SHALL occur when upd_valid=1 and stall=0.
REQ-014 Update rule: if upd_taken=1, table[upd_idx] increments, saturating at 2^CNT_W-1; else it decrements, saturating at 0. No wrap-around.
REQ-015 MODE=1 update SHALL also shift ghr: ghr <= {ghr[IDX_W-2:0], upd_taken}. When IDX_W=1, ghr <= upd_taken. ghr SHALL be non-speculative.
REQ-016 Each update SHALL increment br_cnt by 1. miss_cnt SHALL also increment when upd_taken != upd_pred. Both saturate at 32'hFFFF_FFFF.
REQ-017 stall=1 SHALL freeze table, ghr and counters. Predictions are still driven.
REQ-018 Only one update per cycle. Entries other than upd_idx SHALL be unchanged.

Reset
REQ-019 rst_n=0 at a clock edge SHALL set: state INIT, pointer 0, ghr 0, br_cnt 0, miss_cnt 0. Outputs ready=0 and pred_taken=0 from the next cycle.
REQ-020 Reset asserted mid-INIT or mid-RUN SHALL restart the full sweep from entry 0, discarding the in-flight update.
REQ-021 Table contents SHALL NOT be reset directly; they become defined only through the INIT sweep.

Structure
REQ-022 Shared package bp_pkg SHALL hold:
- opcode constants BEQ=6'b000100 and BNE=6'b000101;
- MODE encodings BP_BIMODAL=0 and BP_GSHARE=1;
- function sat_update(cnt, taken, CNT_W).
REQ-023 One sub-module, bp_sat_counter, SHALL implement the saturating next-value logic. It is purely combinational and instantiated once on the update path.
REQ-024 Table SHALL be a flop array, 2^IDX_W x CNT_W, with one write port and one combinational read port.

Verification
REQ-025 Init (IDX_W=4, CNT_W=2): release rst_n -> ready=0 for exactly 16 cycles then 1; pred_taken=0 for if_pc 0x00..0x3C.
REQ-026 Saturation: 3 taken updates to idx 5 -> counter 1->2->3->3; pred_taken=1 for if_pc 0x14 after the first update. 3 not-taken updates -> 2->1->0, pred_taken=0 after the second.
REQ-027 Stall/INIT gating: upd_valid=1 with stall=1, or during INIT -> table[5], br_cnt and miss_cnt unchanged.
REQ-028 Statistics: 4 updates with upd_pred!=upd_taken on 2 of them -> br_cnt=4, miss_cnt=2. Preloaded 32'hFFFF_FFFE plus 2 updates -> holds at 32'hFFFF_FFFF.
REQ-029 Gshare (MODE=1, IDX_W=4): 2 taken updates -> ghr=4'b0011; if_pc=0x40 -> pred_idx=3.
REQ-030 Mid-operation reset: rst_n=0 for 1 cycle at INIT pointer 7, or in RUN after updates -> ready low 16 cycles, all entries read 1 and counters 0 afterward. CNT_W=1 run: one mispredict toggles pred_taken.
